// File: rtl/control_pkg.sv
// Shared control encodings and the packed control word.
// Holds opcode constants, per-opcode field encodings and the bubble word.
package control_pkg;

  localparam int unsigned OP_NOP    = 0;
  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_SUB    = 2;
  localparam int unsigned OP_LOAD   = 3;
  localparam int unsigned OP_STORE  = 4;
  localparam int unsigned OP_BRANCH = 5;

  typedef struct packed {
    logic [3:0] calc;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       illegal;
  } ctrlWord_t;

  localparam ctrlWord_t CW_BUBBLE = '0;
  localparam ctrlWord_t CW_NOP    = '{4'b0000, 3'b000, 2'b00, 1'b0};
  localparam ctrlWord_t CW_ADD    = '{4'b0010, 3'b000, 2'b10, 1'b0};
  localparam ctrlWord_t CW_SUB    = '{4'b0110, 3'b000, 2'b10, 1'b0};
  localparam ctrlWord_t CW_LOAD   = '{4'b0010, 3'b100, 2'b11, 1'b0};
  localparam ctrlWord_t CW_STORE  = '{4'b0010, 3'b010, 2'b00, 1'b0};
  localparam ctrlWord_t CW_BRANCH = '{4'b0110, 3'b001, 2'b00, 1'b0};

endpackage

// File: rtl/pipeline_control_if.sv
// Decode-side handshake and per-stage control outputs of pipeline_control.
// master: decode/test side drives opCode/opValid/stall/flush; slave: pipeline_control.
interface pipeline_control_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CALC_WIDTH   = 4,
  parameter int MEM_WIDTH    = 3,
  parameter int WB_WIDTH     = 2
);
  logic [OPCODE_WIDTH-1:0] opCode;
  logic                    opValid;
  logic                    stall;
  logic                    flush;
  logic [CALC_WIDTH-1:0]   calculationControl;
  logic                    exValid;
  logic [MEM_WIDTH-1:0]    memAccessControl;
  logic                    memValid;
  logic [WB_WIDTH-1:0]     writeBackControl;
  logic                    wbValid;
`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
  logic                    illegalOp;

  modport master (
    output opCode, opValid, stall, flush,
    input  calculationControl, exValid,
    input  memAccessControl, memValid,
    input  writeBackControl, wbValid,
    input  illegalOp
  );
  modport slave (
    input  opCode, opValid, stall, flush,
    output calculationControl, exValid,
    output memAccessControl, memValid,
    output writeBackControl, wbValid,
    output illegalOp
  );
`else
  modport master (
    output opCode, opValid, stall, flush,
    input  calculationControl, exValid,
    input  memAccessControl, memValid,
    input  writeBackControl, wbValid
  );
  modport slave (
    input  opCode, opValid, stall, flush,
    output calculationControl, exValid,
    output memAccessControl, memValid,
    output writeBackControl, wbValid
  );
`endif
endinterface

// File: rtl/control_decode.sv
// Combinational opcode -> control word decoder (shared with single-cycle path).
// Ports: opCode in; word = decoded control word; legal = opcode is defined.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic [OPCODE_WIDTH-1:0] opCode,
  output ctrlWord_t               word,
  output logic                    legal
);

  always_comb begin
    word  = CW_BUBBLE;
    legal = 1'b1;
    unique case (1'b1)
      (opCode == OPCODE_WIDTH'(OP_NOP)):    word = CW_NOP;
      (opCode == OPCODE_WIDTH'(OP_ADD)):    word = CW_ADD;
      (opCode == OPCODE_WIDTH'(OP_SUB)):    word = CW_SUB;
      (opCode == OPCODE_WIDTH'(OP_LOAD)):   word = CW_LOAD;
      (opCode == OPCODE_WIDTH'(OP_STORE)):  word = CW_STORE;
      (opCode == OPCODE_WIDTH'(OP_BRANCH)): word = CW_BRANCH;
      default: begin
        word.illegal = 1'b1;
        legal        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_control.sv
// Registered EX -> MEM -> WB control pipeline with stall and flush.
// Ports: clk, reset (sync, active-high), bus (slave modport of pipeline_control_if).
// Option: PIPELINE_CONTROL_ILLEGAL_TRAP_EN adds illegalOp and keeps illegal ops live.
module pipeline_control
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int CALC_WIDTH   = 4,
  parameter int MEM_WIDTH    = 3,
  parameter int WB_WIDTH     = 2
) (
  input logic               clk,
  input logic               reset,
  pipeline_control_if.slave bus
);

  ctrlWord_t decWord;
  logic      decLegal;
  logic      takeOp;
  ctrlWord_t exWord, memWord, wbWord;
  logic      exV, memV, wbV;

  control_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) uDecode (
    .opCode(bus.opCode),
    .word  (decWord),
    .legal (decLegal)
  );

`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
  // Illegal ops stay live so the trap bit reaches EX.
  assign takeOp = bus.opValid;
`else
  assign takeOp = bus.opValid & decLegal;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      exWord  <= CW_BUBBLE;
      memWord <= CW_BUBBLE;
      wbWord  <= CW_BUBBLE;
      exV     <= 1'b0;
      memV    <= 1'b0;
      wbV     <= 1'b0;
    end else begin
      // WB always drains MEM so a branch in MEM completes.
      wbWord <= memWord;
      wbV    <= memV;
      if (bus.flush) begin
        exWord  <= CW_BUBBLE;
        exV     <= 1'b0;
        memWord <= CW_BUBBLE;
        memV    <= 1'b0;
      end else if (bus.stall) begin
        memWord <= CW_BUBBLE;
        memV    <= 1'b0;
      end else begin
        exWord  <= takeOp ? decWord : CW_BUBBLE;
        exV     <= takeOp;
        memWord <= exWord;
        memV    <= exV;
      end
    end
  end

  assign bus.calculationControl = CALC_WIDTH'(exWord.calc);
  assign bus.exValid            = exV;
  assign bus.memAccessControl   = MEM_WIDTH'(memWord.mem);
  assign bus.memValid           = memV;
  assign bus.writeBackControl   = WB_WIDTH'(wbWord.wb);
  assign bus.wbValid            = wbV;

`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
  assign bus.illegalOp = exWord.illegal;
  logic unusedBits;
  assign unusedBits = ^{exWord.mem, exWord.wb,
                        memWord.calc, memWord.wb, memWord.illegal,
                        wbWord.calc, wbWord.mem, wbWord.illegal};
`else
  logic unusedBits;
  assign unusedBits = ^{exWord.mem, exWord.wb, exWord.illegal,
                        memWord.calc, memWord.wb, memWord.illegal,
                        wbWord.calc, wbWord.mem, wbWord.illegal};
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control.
// Steps inputs one cycle at a time and checks outputs 1 time unit after each edge.
module tb_pipeline_control;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  pipeline_control_if #(
    .OPCODE_WIDTH(6), .CALC_WIDTH(4), .MEM_WIDTH(3), .WB_WIDTH(2)
  ) bus ();

  pipeline_control #(
    .OPCODE_WIDTH(6), .CALC_WIDTH(4), .MEM_WIDTH(3), .WB_WIDTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step(input logic [5:0] op, input logic v,
                      input logic st, input logic fl, input logic rs);
    bus.opCode  = op;
    bus.opValid = v;
    bus.stall   = st;
    bus.flush   = fl;
    reset       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chkEx(input string tag, input logic [3:0] c,
                       input logic v);
    chk({tag, ".calc"}, 8'(bus.calculationControl), 8'(c));
    chk({tag, ".exV"}, 8'(bus.exValid), 8'(v));
  endtask

  task automatic chkMem(input string tag, input logic [2:0] m,
                        input logic v);
    chk({tag, ".mem"}, 8'(bus.memAccessControl), 8'(m));
    chk({tag, ".memV"}, 8'(bus.memValid), 8'(v));
  endtask

  task automatic chkWb(input string tag, input logic [1:0] w,
                       input logic v);
    chk({tag, ".wb"}, 8'(bus.writeBackControl), 8'(w));
    chk({tag, ".wbV"}, 8'(bus.wbValid), 8'(v));
  endtask

  initial begin
    // reset for 2 cycles
    step(6'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(6'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    chkEx("rst", 4'b0000, 1'b0);
    chkMem("rst", 3'b000, 1'b0);
    chkWb("rst", 2'b00, 1'b0);
`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
    chk("rst.ill", 8'(bus.illegalOp), 8'd0);
`endif

    // stream ADD, LOAD, STORE, BRANCH
    step(6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("s1", 4'b0010, 1'b1);
    chkMem("s1", 3'b000, 1'b0);
    step(6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("s2", 4'b0010, 1'b1);
    chkMem("s2", 3'b000, 1'b1);
    chkWb("s2", 2'b00, 1'b0);
    step(6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("s3", 4'b0010, 1'b1);
    chkMem("s3", 3'b100, 1'b1);
    chkWb("s3", 2'b10, 1'b1);
    step(6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("s4", 4'b0110, 1'b1);
    chkMem("s4", 3'b010, 1'b1);
    chkWb("s4", 2'b11, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkEx("s5", 4'b0000, 1'b0);
    chkMem("s5", 3'b001, 1'b1);
    chkWb("s5", 2'b00, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkMem("s6", 3'b000, 1'b0);
    chkWb("s6", 2'b00, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("s7", 2'b00, 1'b0);

    // stall LOAD in EX for 2 cycles; opCode presented meanwhile is ignored
    step(6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("st0", 4'b0010, 1'b1);
    step(6'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    chkEx("st1", 4'b0010, 1'b1);
    chkMem("st1", 3'b000, 1'b0);
    step(6'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    chkEx("st2", 4'b0010, 1'b1);
    chkMem("st2", 3'b000, 1'b0);
    chkWb("st2", 2'b00, 1'b0);
    step(6'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("st3", 4'b0110, 1'b1);
    chkMem("st3", 3'b100, 1'b1);
    chkWb("st3", 2'b00, 1'b0);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkMem("st4", 3'b000, 1'b1);
    chkWb("st4", 2'b11, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("st5", 2'b10, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("st6", 2'b00, 1'b0);

    // flush with BRANCH in MEM, ADD in EX
    step(6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("fl0", 4'b0010, 1'b1);
    chkMem("fl0", 3'b001, 1'b1);
    step(6'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    chkEx("fl1", 4'b0000, 1'b0);
    chkMem("fl1", 3'b000, 1'b0);
    chkWb("fl1", 2'b00, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("fl2", 2'b00, 1'b0);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("fl3", 2'b00, 1'b0);

    // flush and stall together: SUB in MEM, ADD in EX
    step(6'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    chkEx("fs1", 4'b0000, 1'b0);
    chkMem("fs1", 3'b000, 1'b0);
    chkWb("fs1", 2'b10, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkEx("fs2", 4'b0000, 1'b0);
    chkMem("fs2", 3'b000, 1'b0);
    chkWb("fs2", 2'b00, 1'b0);

    // reset mid-stream
    step(6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("rm0", 4'b0010, 1'b1);
    chkMem("rm0", 3'b100, 1'b1);
    chkWb("rm0", 2'b10, 1'b1);
    step(6'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    chkEx("rm1", 4'b0000, 1'b0);
    chkMem("rm1", 3'b000, 1'b0);
    chkWb("rm1", 2'b00, 1'b0);
    step(6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chkEx("rm2", 4'b0110, 1'b1);
    chkMem("rm2", 3'b000, 1'b0);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkMem("rm3", 3'b001, 1'b1);
    chkWb("rm3", 2'b00, 1'b0);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkWb("rm4", 2'b00, 1'b1);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // illegal opcode 63
    step(6'd63, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
    chkEx("il1", 4'b0000, 1'b1);
    chk("il1.ill", 8'(bus.illegalOp), 8'd1);
`else
    chkEx("il1", 4'b0000, 1'b0);
`endif
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkEx("il2", 4'b0000, 1'b0);
`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
    chk("il2.ill", 8'(bus.illegalOp), 8'd0);
    chkMem("il2", 3'b000, 1'b1);
`else
    chkMem("il2", 3'b000, 1'b0);
`endif
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINE_CONTROL_ILLEGAL_TRAP_EN
    chkWb("il3", 2'b00, 1'b1);
`else
    chkWb("il3", 2'b00, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Pipelined successor to the combinational `Control` decoder. Decodes an opcode into calculation, memory-access and write-back control fields, then carries each field down a registered EX → MEM → WB pipeline so that every downstream stage sees the control belonging to its own instruction. The block supports stall (bubble insertion) and flush, and its field widths are parametrised. It sits between instruction fetch/decode and the datapath stage registers.

## Interface
- `OPCODE_WIDTH`, 6, opcode width
- `CALC_WIDTH`, 4, calculation (ALU) control width
- `MEM_WIDTH`, 3, memory-access control width
- `WB_WIDTH`, 2, write-back control width
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `opCode` input OPCODE_WIDTH: instruction opcode at the decode stage
- `opValid` input 1: `opCode` holds a real instruction
- `stall` input 1: hold the EX stage and insert a bubble into MEM
- `flush` input 1: kill the instructions in EX and MEM
- `calculationControl` output CALC_WIDTH: EX-stage control
- `exValid` output 1: EX stage holds a live instruction
- `memAccessControl` output MEM_WIDTH: MEM-stage control as {memRead, memWrite, branch}
- `memValid` output 1: MEM stage holds a live instruction
- `writeBackControl` output WB_WIDTH: WB-stage control as {regWrite, memToReg}
- `wbValid` output 1: WB stage holds a live instruction
- `illegalOp` output 1: present only under the configuration macro

## Operation
- Decode table:
  - 0 NOP: calc 0000, mem 000, wb 00
  - 1 ADD: calc 0010, mem 000, wb 10
  - 2 SUB: calc 0110, mem 000, wb 10
  - 3 LOAD: calc 0010, mem 100, wb 11
  - 4 STORE: calc 0010, mem 010, wb 00
  - 5 BRANCH: calc 0110, mem 001, wb 00
  - All other opcodes decode to all-zero fields, i.e. a bubble.
- A field is zero-extended or truncated to its parameter width. Fixed encodings occupy the LSBs.
- Stage registers hold the full decoded word. Each stage outputs only its own field, and carries the remaining fields forward.
- A bubble has all fields zero and valid 0. An `opValid=0` input enters EX as a bubble.
- Stall (with flush=0):
  - EX holds its contents.
  - MEM loads a bubble.
  - WB loads the old MEM contents.
- Flush:
  - EX and MEM load bubbles.
  - WB loads the old MEM contents, so the branch in MEM completes.
  - Flush has priority over stall.
- Reset forces every stage register, every valid and every output to 0. It overrides stall and flush, and takes effect mid-stream with no partial instruction surviving.

## Timing
- An opcode sampled at edge N appears on `calculationControl` after edge N, on `memAccessControl` after N+1, and on `writeBackControl` after N+2. Latency from input to each stage is 1, 2 and 3 cycles respectively.
- All outputs are registered. There is no combinational path from input to output.
- Throughput is one instruction per cycle when not stalled.
- Each cycle of stall inserts exactly one bubble. A stall held for k cycles delays the held instruction by k cycles.
- During stall, the `opCode` presented is ignored; the decode stage upstream must hold it.

## Configuration
- Macro: `PIPELINE_CONTROL_ILLEGAL_TRAP_EN`.
- When defined:
  - An undefined opcode with `opValid=1` sets an illegal bit that travels with the instruction.
  - `illegalOp` asserts while that instruction is in EX.
  - The instruction is still a bubble for every control field, but `exValid` is 1.
- When not defined:
  - Undefined opcodes are silently bubbles with `exValid` 0.
  - The `illegalOp` port does not exist.

## Structure
- Package `control_pkg` holds:
  - opcode constants (NOP..BRANCH)
  - per-opcode field encodings
  - a packed typedef of the control word {calc, mem, wb, illegal}
- Sub-module `control_decode`: purely combinational opcode → control word. It is reusable by the single-cycle datapath.
- The top level holds the three stage registers and the stall/flush logic.

## Test plan
- **Reset then stream:** reset for 2 cycles, then opCodes 1, 3, 4, 5 one per cycle, valid.
  - `calculationControl` shows 0010, 0010, 0010, 0110 from cycle 1.
  - `memAccessControl` shows 000, 100, 010, 001 from cycle 2.
  - `writeBackControl` shows 10, 11, 00, 00 from cycle 3.
- **Stall:** LOAD(3) in EX, stall=1 for 2 cycles.
  - `calculationControl` stays 0010 for 3 cycles.
  - MEM shows two bubbles (000, `memValid`=0), then 100.
  - WB sequence is correct with no duplication.
- **Flush:** BRANCH(5) in MEM, ADD in EX, flush=1 for 1 cycle.
  - Next cycle EX and MEM are bubbles.
  - WB holds the branch word (wb 00, `wbValid` 1).
  - The ADD never produces wb 10.
- **Flush and stall together:** assert both for 1 cycle.
  - Behaviour identical to flush alone.
  - EX does not retain its instruction.
- **Reset mid-stream:** with all stages valid, assert reset for 1 cycle.
  - All outputs and valids are 0 on the next cycle.
  - The next opcode reappears after the normal 1/2/3-cycle latency.
- **Illegal opcode:** opCode 63 with opValid=1.
  - Fields are all zero in every stage.
  - With the macro defined: `illegalOp`=1 and `exValid`=1 for exactly one cycle.
  - Without the macro: `exValid`=0.
